// File: rtl/ct_pkg.sv
// Shared definitions for the ct_* stream nodes (merge/split).
// Beat layout, LSB first: data [WO], flow_id [WF], eop [1].
package ct_pkg;

  // Ceiling log2, never less than 1 bit so single-entry indices stay legal.
  function automatic int ct_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int ct_beat_w(input int wo, input int wf);
    return wo + wf + 1;
  endfunction

  function automatic int ct_flow_lsb(input int wo);
    return wo;
  endfunction

  function automatic int ct_eop_bit(input int wo, input int wf);
    return wo + wf;
  endfunction

endpackage

// File: rtl/ct_merge_if.sv
// Handshake bundle for ct_merge: NI upstream streams in, one merged stream out.
interface ct_merge_if #(
  parameter int NI = 2,
  parameter int WO = 8,
  parameter int WF = 4
);
  logic [NI*WO-1:0] i_data;
  logic [NI-1:0]    i_valid;
  logic [NI*WF-1:0] i_flow;
  logic [NI-1:0]    i_eop;
  logic [NI-1:0]    o_ready;
  logic [WO-1:0]    o_data;
  logic             o_valid;
  logic [WF-1:0]    o_flow;
  logic             o_eop;
  logic             i_ready;

  modport master (
    output i_data, i_valid, i_flow, i_eop, i_ready,
    input  o_ready, o_data, o_valid, o_flow, o_eop
  );

  modport slave (
    input  i_data, i_valid, i_flow, i_eop, i_ready,
    output o_ready, o_data, o_valid, o_flow, o_eop
  );
endinterface

// File: rtl/ct_rr_arb.sv
// Round-robin arbiter: scans from last_grant+1 with explicit wrap at N-1;
// a held lock overrides the scan. With no requests the next-in-turn index is offered.
module ct_rr_arb
  import ct_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req,
  input  logic                   lock,
  input  logic [ct_clog2(N)-1:0] lock_sel,
  input  logic                   advance,
  input  logic [ct_clog2(N)-1:0] grant_idx,
  output logic [N-1:0]           gnt,
  output logic [ct_clog2(N)-1:0] idx
);
  localparam int W = ct_clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] last_grant;
  logic [W-1:0] k;
  logic         found;

  always_ff @(posedge clk) begin
    if (reset)        last_grant <= LAST;
    else if (advance) last_grant <= grant_idx;
  end

  always_comb begin
    k     = last_grant;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      k = (k == LAST) ? '0 : k + W'(1);
      if (i == 0) idx = k;
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
    if (lock) idx = lock_sel;
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) gnt[i] = (idx == W'(i));
  end

endmodule

// File: rtl/ct_merge.sv
// Many-to-one merge with one registered output stage and round-robin arbitration.
// Define CT_MERGE_LOCK_EN to hold multi-beat packets on one input until eop.
module ct_merge
  import ct_pkg::*;
#(
  parameter int NI = 2,
  parameter int WO = 8,
  parameter int WF = 4
) (
  input  logic        clk,
  input  logic        reset,
  ct_merge_if.slave   bus
);
  localparam int W   = ct_clog2(NI);
  localparam int BW  = ct_beat_w(WO, WF);
  localparam int EOP = ct_eop_bit(WO, WF);

  logic          load;
  logic          xfer;
  logic          locked;
  logic [W-1:0]  lock_sel;
  logic [W-1:0]  g;
  logic [NI-1:0] gnt;
  logic [BW-1:0] beat_sel;
  logic [BW-1:0] out_beat;
  logic          out_valid;

  ct_rr_arb #(.N(NI)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.i_valid),
    .lock      (locked),
    .lock_sel  (lock_sel),
    .advance   (xfer),
    .grant_idx (g),
    .gnt       (gnt),
    .idx       (g)
  );

  assign load        = !out_valid || bus.i_ready;
  assign bus.o_ready = load ? gnt : '0;
  assign xfer        = |(bus.i_valid & bus.o_ready);

  always_comb begin
    beat_sel = '0;
    for (int k = 0; k < NI; k++) begin
      if (g == W'(k))
        beat_sel = {bus.i_eop[k], bus.i_flow[k*WF +: WF], bus.i_data[k*WO +: WO]};
    end
  end

  // Data registers only move on a transfer; an idle load just drops valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) out_beat <= beat_sel;
    end
  end

`ifdef CT_MERGE_LOCK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      locked   <= 1'b0;
      lock_sel <= '0;
    end else if (xfer) begin
      locked <= !beat_sel[EOP];
      if (!beat_sel[EOP]) lock_sel <= g;
    end
  end
`else
  assign locked   = 1'b0;
  assign lock_sel = '0;
`endif

  assign bus.o_valid = out_valid;
  assign bus.o_data  = out_beat[WO-1:0];
  assign bus.o_flow  = out_beat[ct_flow_lsb(WO) +: WF];
  assign bus.o_eop   = out_beat[EOP];

endmodule

// File: doc/ct_merge.md
Name: ct_merge

Overview:
- Many-to-one merge node. Arbitrates NI upstream streams onto one output, using valid/ready handshakes with flow_id sideband.
- Sits directly upstream of a split node. Its output feeds the split's i_data/i_valid/i_flow/o_ready interface.
- One registered output stage and round-robin arbitration. When locking is compiled in, a multi-beat packet is held on one input until its end-of-packet beat.

Parameters:
- NI, 2, number of inputs (>=1)
- WO, 8, data width per input/output
- WF, 4, flow_id width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- i_data  input  NI*WO  per-input data, input k at [k*WO +: WO]
- i_valid  input  NI  per-input valid
- i_flow  input  NI*WF  per-input flow_id, input k at [k*WF +: WF]
- i_eop  input  NI  per-input end-of-packet marker
- o_ready  output  NI  per-input ready (back to upstream)
- o_data  output  WO  merged data (registered)
- o_valid  output  1  merged valid (registered)
- o_flow  output  WF  merged flow_id (registered)
- o_eop  output  1  merged end-of-packet (registered)
- i_ready  input  1  downstream ready

Behaviour:
- Reset (sync, high, at posedge clk):
  - o_valid=0, o_data=0, o_flow=0, o_eop=0.
  - last_grant=NI-1, so input 0 wins first.
  - locked=0, lock_sel=0.
  - o_ready is combinational and therefore 0 while o_valid... see load rule.
- Load rule: load = !o_valid | i_ready. This gives full throughput, one beat per cycle.
- Grant (combinational):
  - When unlocked: g = first k with i_valid[k]=1, scanning last_grant+1, +2, ... modulo NI.
  - When locked: g = lock_sel.
- Ready: o_ready[k] = load & (k==g). Never more than one bit set. Ready is allowed to assert without a matching valid.
- Transfer on input g: i_valid[g] & o_ready[g]. At the next posedge:
  - o_data, o_flow, o_eop capture input g's fields; o_valid<=1.
  - last_grant<=g.
- When load=1 and no input transfers: o_valid<=0 and the data registers hold their value.
- Stall: while o_valid & !i_ready, all output registers hold stable and no o_ready bit is set.
- Latency: 1 cycle from input transfer to o_valid.
- Flow_id passes unmodified.
- Fairness: each valid input is granted within NI transfers, or NI packets when locking is enabled.
- Simultaneous valids: round-robin only, no fixed priority. After granting k, input k has lowest priority.
- NI=1: the block degenerates to a single pipeline register and grant is always 0.
- Index arithmetic: last_grant width is clog2(NI), minimum 1 bit. Wrap-around uses explicit compare to NI-1, not a power-of-two mask.
- Reset mid-packet: lock is cleared and any in-flight output beat is dropped. Upstream must restart the packet.

Optional Feature:
- Macro: CT_MERGE_LOCK_EN.
- Defined (packet locking):
  - On a transfer with i_eop[g]=0: locked<=1, lock_sel<=g.
  - On a transfer with i_eop[g]=1: locked<=0.
  - While locked, other inputs stall even if valid, and an idle locked input blocks the merge.
- Undefined: arbitration is per beat and i_eop is only forwarded to o_eop. Beats from different inputs may interleave.

Decomposition:
- Shared package ct_pkg holds:
  - a clog2 constant function;
  - a common handshake field-layout definition (data/flow/eop ordering), also used by the split node.
- Natural sub-module ct_rr_arb, parameter N:
  - inputs: req[N], lock, lock_sel, advance, grant_idx;
  - outputs: one-hot gnt and index;
  - holds last_grant internally.
- ct_merge instantiates one ct_rr_arb plus the output register and lock logic.

Test Plan:
- Reset then idle: assert reset 2 cycles, all i_valid=0. Required: o_valid=0, o_data=0, o_ready=2'b01 (grant defaults to input 0) with load=1.
- Single stream, NI=2, i_ready=1: input 0 sends data 0x11, 0x22, 0x33 with flow 3 on consecutive cycles. Required: o_data 0x11, 0x22, 0x33 with o_flow=3 one cycle later each, no bubbles.
- Contention, no lock: i_valid=2'b11 every cycle, input 0 data 0xA0, input 1 data 0xB0. Required: output alternates 0xA0, 0xB0, 0xA0, ...
- Backpressure: hold i_ready=0 for 3 cycles with o_valid=1, o_data=0x5C. Required: o_data stays 0x5C, o_ready=0, and nothing is lost. On release, the next beat follows the next cycle.
- Locking (CT_MERGE_LOCK_EN): input 1 sends a 3-beat packet (eop on beat 3) while input 0 is valid throughout. Required: all 3 input-1 beats are contiguous at the output, input 0 gets its first grant on the cycle after the eop transfer, and o_eop=1 on beat 3 only.
- Reset mid-packet (CT_MERGE_LOCK_EN): assert reset after beat 1 of a locked packet on input 1. Required: o_valid=0 and lock cleared the next cycle, and input 0 is granted first after reset.
